outer_product_streamer: RTL and testbench

Single-clock outer-product engine. It serially loads two 16-element 4-bit vectors A and B under in_valid. It then streams all 256 products A[i]*B[j] in row-major order (i outer, j inner) as 8-bit values under out_valid/out_ready. It is the design-side end of the lab's in_valid / in_matrix_A / in_matrix_B → out_valid / out_matrix protocol, and the single-clock reference the team uses to check the CDC versions against.

---
 rtl/outer_product_streamer.sv | 142 ++++++++++++++
 tb/tb_outer_product_streamer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/outer_product_streamer.sv
// rtl/outer_product_streamer.sv - serial load of two vectors, row-major stream of all pairwise products
module outer_product_streamer #(
    parameter int VEC_LEN = 16,
    parameter int IN_W    = 4,
    parameter int OUT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_matrix_A,
    input  logic [IN_W-1:0]  in_matrix_B,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_matrix
);

    localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_OUT
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [IN_W-1:0] a_mem [VEC_LEN];
    logic [IN_W-1:0] b_mem [VEC_LEN];

    logic [CW-1:0]   count;
    logic [CW-1:0]   i;
    logic [CW-1:0]   j;
    logic [CW-1:0]   i_nxt;
    logic [CW-1:0]   j_nxt;

    logic            load_fire;
    logic            load_last;
    logic            start;
    logic            xfer;
    logic            xfer_last;

    function automatic logic [OUT_W-1:0] mul(input logic [IN_W-1:0] x, input logic [IN_W-1:0] y);
        return OUT_W'(x) * OUT_W'(y);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // in_valid is only honoured outside S_OUT, so stray pulses during a stream are dropped.
    always_comb begin
        state_next = state;
        load_fire  = 1'b0;
        load_last  = 1'b0;
        start      = 1'b0;
        xfer       = 1'b0;
        xfer_last  = 1'b0;
        case (state)
            S_IDLE, S_LOAD: begin
                if (in_valid) begin
                    load_fire = 1'b1;
                    if (count == LAST) begin
                        load_last  = 1'b1;
                        state_next = S_OUT;
                    end else begin
                        state_next = S_LOAD;
                    end
                end
            end
            S_OUT: begin
                if (!out_valid) begin
                    start = 1'b1;
                end else if (out_ready) begin
                    xfer = 1'b1;
                    if (i == LAST && j == LAST) begin
                        xfer_last  = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        if (j == LAST) begin
            j_nxt = '0;
            i_nxt = i + 1'b1;
        end else begin
            j_nxt = j + 1'b1;
            i_nxt = i;
        end
    end

    // Vector storage has no reset: a reset only aborts, the next load overwrites every entry.
    always_ff @(posedge clk) begin
        if (rst_n && load_fire) begin
            a_mem[count] <= in_matrix_A;
            b_mem[count] <= in_matrix_B;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count      <= '0;
            i          <= '0;
            j          <= '0;
            out_valid  <= 1'b0;
            out_matrix <= '0;
        end else begin
            if (load_fire) begin
                count <= load_last ? '0 : count + 1'b1;
            end
            if (load_last) begin
                i <= '0;
                j <= '0;
            end
            if (start) begin
                out_valid  <= 1'b1;
                out_matrix <= mul(a_mem[0], b_mem[0]);
            end else if (xfer) begin
                if (xfer_last) begin
                    out_valid  <= 1'b0;
                    out_matrix <= '0;
                    i          <= '0;
                    j          <= '0;
                end else begin
                    i          <= i_nxt;
                    j          <= j_nxt;
                    out_matrix <= mul(a_mem[i_nxt], b_mem[j_nxt]);
                end
            end
        end
    end

endmodule

// File: tb/tb_outer_product_streamer.sv
// tb/tb_outer_product_streamer.sv - randomized bench with a queue-based outer-product model
module tb_outer_product_streamer;

    localparam int VL = 16;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_matrix_A;
    logic [3:0] in_matrix_B;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_matrix;

    outer_product_streamer #(.VEC_LEN(VL), .IN_W(4), .OUT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_matrix_A (in_matrix_A),
        .in_matrix_B (in_matrix_B),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_matrix  (out_matrix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   a_v [VL];
    int   b_v [VL];
    int   exp_q [$];
    int   got [VL*VL];
    int   xfer_idx = 0;
    int   last_load_cyc = 0;
    int   first_cyc = 0;
    int   last_xfer_cyc = 0;
    bit   first_pending = 1'b0;
    bit   rand_ready = 1'b0;
    bit   stall_prev = 1'b0;
    logic [7:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Every falling edge: hold rules, idle-zero rule, and accepted values against the model queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_matrix, held);
            end
            if (!out_valid) begin
                check("idle_zero", out_matrix, 0);
            end else begin
                if (first_pending) begin
                    check("first_latency", cyc, last_load_cyc + 1);
                    first_pending = 1'b0;
                    first_cyc = cyc;
                end
                if (exp_q.size() == 0) begin
                    check("spurious_valid", out_valid, 0);
                end else if (out_ready) begin
                    check("data", out_matrix, exp_q[0]);
                    if (xfer_idx < VL*VL) got[xfer_idx] = out_matrix;
                    xfer_idx++;
                    last_xfer_cyc = cyc;
                    void'(exp_q.pop_front());
                end
            end
            stall_prev = out_valid && !out_ready;
            held = out_matrix;
        end
    end

    task automatic load(input int gap_after, input int gap_len);
        for (int k = 0; k < VL; k++) begin
            in_valid    = 1'b1;
            in_matrix_A = 4'(a_v[k]);
            in_matrix_B = 4'(b_v[k]);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (k == VL - 1) last_load_cyc = cyc;
            if (k == gap_after) repeat (gap_len) begin @(posedge clk); #1; end
        end
        exp_q.delete();
        for (int r = 0; r < VL; r++)
            for (int c = 0; c < VL; c++)
                exp_q.push_back(a_v[r] * b_v[c]);
        xfer_idx = 0;
        first_pending = 1'b1;
    endtask

    task automatic drain(input bit viol);
        int budget = 3000;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
            if (viol && exp_q.size() >= 2 && $urandom_range(0, 15) == 0) begin
                in_valid    = 1'b1;
                in_matrix_A = 4'($urandom);
                in_matrix_B = 4'($urandom);
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        if (budget == 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        check("xfer_count", xfer_idx, VL*VL);
        if (!rand_ready) check("contiguous_span", last_xfer_cyc - first_cyc, VL*VL - 1);
        @(negedge clk);
        check("end_valid", out_valid, 0);
    endtask

    task automatic reset_at(input int idx);
        int budget = 3000;
        while (xfer_idx < idx && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("reset_wait_timeout", xfer_idx, idx);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        first_pending = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_data", out_matrix, 0);
    endtask

    task automatic fill_random(input int mode);
        for (int k = 0; k < VL; k++) begin
            case (mode)
                0: begin a_v[k] = 15; b_v[k] = 15; end
                1: begin a_v[k] = 0; b_v[k] = $urandom_range(0, 15); end
                default: begin a_v[k] = $urandom_range(0, 15); b_v[k] = $urandom_range(0, 15); end
            endcase
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_matrix_A = '0;
        in_matrix_B = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("reset_valid", out_valid, 0);
        end

        for (int k = 0; k < VL; k++) begin a_v[k] = k; b_v[k] = 15 - k; end
        load(-1, 0);
        drain(1'b0);
        check("ramp_out0", got[0], 0);
        check("ramp_out1", got[1], 0);
        check("ramp_out16", got[16], 15);
        check("ramp_out17", got[17], 14);
        check("ramp_out255", got[255], 0);
        check("ramp_out255_alt", got[VL*VL-2], 15 * 1);

        fill_random(0);
        load(-1, 0);
        drain(1'b0);
        check("max_out0", got[0], 225);
        check("max_out200", got[200], 225);

        for (int k = 0; k < VL; k++) a_v[k] = 0;
        load(-1, 0);
        drain(1'b0);
        check("zero_out128", got[128], 0);

        rand_ready = 1'b1;
        fill_random(2);
        load(-1, 0);
        drain(1'b0);
        rand_ready = 1'b0;

        fill_random(2);
        load(7, 3);
        drain(1'b1);

        fill_random(2);
        load(-1, 0);
        reset_at(100);
        fill_random(2);
        load(-1, 0);
        drain(1'b0);

        for (int p = 0; p < 100; p++) begin
            fill_random(($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : 2);
            rand_ready = ($urandom_range(0, 1) == 1);
            load(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 14)) : -1, $urandom_range(1, 4));
            if ($urandom_range(0, 7) == 0) begin
                reset_at($urandom_range(1, 250));
            end else begin
                drain($urandom_range(0, 1) == 1);
            end
        end
        rand_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
